// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor
//   Measures incoming VGA sync timing against expected parameters and
//   reports lock status.
//
//   Parameters:
//     H_PERIOD - expected clk_100 cycles between hsync falling edges
//     H_PULSE  - expected clk_100 cycles hsync is low
//     V_LINES  - expected hsync falling edges between vsync falling edges
//     V_PULSE  - expected hsync falling edges while vsync is low
//
//   Ports:
//     clk_100      in   system clock, rising edge
//     rst          in   asynchronous active-high reset
//     hsync        in   asynchronous active-low horizontal sync
//     vsync        in   asynchronous active-low vertical sync
//     h_period     out  last measured line period (cycles)
//     h_pulse      out  last measured hsync low width (cycles)
//     v_lines      out  last measured lines per frame
//     v_pulse      out  last measured vsync width (lines)
//     locked       out  timing matches all parameters
//     no_signal    out  hsync timeout
//     frame_strobe out  one-cycle pulse per evaluated frame
module vga_sync_monitor #(
    parameter int unsigned H_PERIOD = 3200,
    parameter int unsigned H_PULSE  = 384,
    parameter int unsigned V_LINES  = 525,
    parameter int unsigned V_PULSE  = 2
) (
    input  logic        clk_100,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    output logic [11:0] h_period,
    output logic [9:0]  h_pulse,
    output logic [9:0]  v_lines,
    output logic [3:0]  v_pulse,
    output logic        locked,
    output logic        no_signal,
    output logic        frame_strobe
);

    localparam logic [11:0] LP_H_PERIOD = 12'(H_PERIOD);
    localparam logic [9:0]  LP_H_PULSE  = 10'(H_PULSE);
    localparam logic [9:0]  LP_V_LINES  = 10'(V_LINES);
    localparam logic [3:0]  LP_V_PULSE  = 4'(V_PULSE);

    typedef enum logic [1:0] {
        SEARCH,
        CHECK,
        LOCKED
    } state_t;

    // Synchronizers and edge-detect delay flops
    logic r_hs_meta, r_hs_sync, r_hs_dly;
    logic r_vs_meta, r_vs_sync, r_vs_dly;

    // Measurement counters and latched results
    logic [11:0] r_per;
    logic [9:0]  r_wid;
    logic [9:0]  r_lines;
    logic [3:0]  r_vw;
    logic [11:0] r_h_period;
    logic [9:0]  r_h_pulse;
    logic [9:0]  r_v_lines;
    logic [3:0]  r_v_pulse;

    // Status
    logic   r_no_signal;
    logic   r_err;
    logic   r_hmis;
    logic   r_strobe;
    state_t r_state;
    state_t w_next;

    logic w_hs_fall, w_hs_rise, w_vs_fall, w_vs_rise;
    logic w_timeout, w_per_bad, w_wid_bad, w_err_now, w_frame_ok;

    assign w_hs_fall = r_hs_dly & ~r_hs_sync;
    assign w_hs_rise = ~r_hs_dly & r_hs_sync;
    assign w_vs_fall = r_vs_dly & ~r_vs_sync;
    assign w_vs_rise = ~r_vs_dly & r_vs_sync;

    assign w_timeout = (r_per == '1);
    assign w_per_bad = w_hs_fall & (r_per != LP_H_PERIOD);
    assign w_wid_bad = w_hs_rise & (r_wid != LP_H_PULSE);
    assign w_err_now = w_per_bad | w_wid_bad | w_timeout;

    // A measurement latched in the evaluation cycle closes the line that
    // ended there, so it is charged to the frame being evaluated.
    assign w_frame_ok = ~r_err & ~w_err_now &
                        (r_lines == LP_V_LINES) & (r_v_pulse == LP_V_PULSE);

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            r_hs_meta <= 1'b1;
            r_hs_sync <= 1'b1;
            r_hs_dly  <= 1'b1;
            r_vs_meta <= 1'b1;
            r_vs_sync <= 1'b1;
            r_vs_dly  <= 1'b1;
        end else begin
            r_hs_meta <= hsync;
            r_hs_sync <= r_hs_meta;
            r_hs_dly  <= r_hs_sync;
            r_vs_meta <= vsync;
            r_vs_sync <= r_vs_meta;
            r_vs_dly  <= r_vs_sync;
        end
    end

    // Line period and hsync width
    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            r_per      <= '0;
            r_wid      <= '0;
            r_h_period <= '0;
            r_h_pulse  <= '0;
        end else begin
            if (w_hs_fall) begin
                r_per      <= 12'd1;
                r_h_period <= r_per;
            end else if (r_per != '1) begin
                r_per <= r_per + 12'd1;
            end

            if (w_hs_fall) begin
                r_wid <= 10'd1;
            end else if (!r_hs_sync && (r_wid != '1)) begin
                r_wid <= r_wid + 10'd1;
            end

            if (w_hs_rise) begin
                r_h_pulse <= r_wid;
            end
        end
    end

    // Lines per frame and vsync width. An hsync fall coincident with the
    // vsync fall starts the new frame, so both counters restart at 1.
    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            r_lines   <= '0;
            r_vw      <= '0;
            r_v_lines <= '0;
            r_v_pulse <= '0;
        end else begin
            if (w_vs_fall) begin
                r_v_lines <= r_lines;
                r_lines   <= {9'd0, w_hs_fall};
            end else if (w_hs_fall && (r_lines != '1)) begin
                r_lines <= r_lines + 10'd1;
            end

            if (w_vs_fall) begin
                r_vw <= {3'd0, w_hs_fall};
            end else if (w_hs_fall && !r_vs_sync && (r_vw != '1)) begin
                r_vw <= r_vw + 4'd1;
            end

            if (w_vs_rise) begin
                r_v_pulse <= r_vw;
            end
        end
    end

    // Error tracking, timeout and frame strobe. The error flag resets set
    // so the partial frame after reset never evaluates as good.
    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            r_no_signal <= 1'b0;
            r_err       <= 1'b1;
            r_hmis      <= 1'b0;
            r_strobe    <= 1'b0;
        end else begin
            if (w_hs_fall) begin
                r_no_signal <= 1'b0;
            end else if (w_timeout) begin
                r_no_signal <= 1'b1;
            end

            if (w_vs_fall) begin
                r_err <= 1'b0;
            end else begin
                r_err <= r_err | w_err_now;
            end

            r_hmis   <= w_per_bad | w_wid_bad;
            r_strobe <= w_vs_fall;
        end
    end

    // Lock FSM
    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            r_state <= SEARCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            SEARCH: begin
                if (w_vs_fall && w_frame_ok) begin
                    w_next = CHECK;
                end
            end
            CHECK: begin
                if (w_vs_fall) begin
                    w_next = w_frame_ok ? LOCKED : SEARCH;
                end
            end
            LOCKED: begin
                if ((w_vs_fall && !w_frame_ok) || r_hmis || w_timeout) begin
                    w_next = SEARCH;
                end
            end
            default: w_next = SEARCH;
        endcase
    end

    assign h_period     = r_h_period;
    assign h_pulse      = r_h_pulse;
    assign v_lines      = r_v_lines;
    assign v_pulse      = r_v_pulse;
    assign locked       = (r_state == LOCKED);
    assign no_signal    = r_no_signal;
    assign frame_strobe = r_strobe;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Testbench for vga_sync_monitor with shortened timing parameters.
// The driver generates directed frames and queues the expected report for
// each frame evaluation; a monitor checks each report on frame_strobe.
module tb_vga_sync_monitor;

    localparam int HP = 40;
    localparam int HW = 6;
    localparam int VL = 10;
    localparam int VP = 2;

    typedef struct packed {
        logic        lk;
        logic        chk_hp;
        logic [11:0] hp;
        logic [9:0]  hw;
        logic [9:0]  vl;
        logic [3:0]  vp;
    } exp_t;

    logic        clk_100 = 1'b0;
    logic        rst;
    logic        hsync;
    logic        vsync;
    logic [11:0] h_period;
    logic [9:0]  h_pulse;
    logic [9:0]  v_lines;
    logic [3:0]  v_pulse;
    logic        locked;
    logic        no_signal;
    logic        frame_strobe;
    logic [38:0] outs;

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    assign outs = {h_period, h_pulse, v_lines, v_pulse, locked, no_signal, frame_strobe};

    vga_sync_monitor #(
        .H_PERIOD (HP),
        .H_PULSE  (HW),
        .V_LINES  (VL),
        .V_PULSE  (VP)
    ) dut (
        .clk_100      (clk_100),
        .rst          (rst),
        .hsync        (hsync),
        .vsync        (vsync),
        .h_period     (h_period),
        .h_pulse      (h_pulse),
        .v_lines      (v_lines),
        .v_pulse      (v_pulse),
        .locked       (locked),
        .no_signal    (no_signal),
        .frame_strobe (frame_strobe)
    );

    always #5 clk_100 = ~clk_100;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input bit lk, input bit chk_hp, input int hp,
                                input int hw, input int vl, input int vp);
        exp_t e;
        e.lk     = lk;
        e.chk_hp = chk_hp;
        e.hp     = 12'(hp);
        e.hw     = 10'(hw);
        e.vl     = 10'(vl);
        e.vp     = 4'(vp);
        return e;
    endfunction

    function automatic exp_t nom(input bit lk);
        return mk(lk, 1'b1, HP, HW, VL, VP);
    endfunction

    // Called at a negedge; drives one line starting with the hsync fall.
    task automatic send_line(input logic vs, input int period,
                             input bit chk_long, input bit chk_ns);
        hsync = 1'b0;
        vsync = vs;
        for (int c = 1; c < period; c++) begin
            @(negedge clk_100);
            if (c == HW) hsync = 1'b1;
            if (chk_long && c == 3) begin
                check("long_h_period", 64'(h_period), 64'(HP + 4));
                check("long_locked_at_latch", 64'(locked), 64'd1);
            end
            if (chk_long && c == 4) check("long_unlock", 64'(locked), 64'd0);
            if (chk_ns && c == 3) begin
                check("ns_clear", 64'(no_signal), 64'd0);
                check("ns_h_period", 64'(h_period), 64'd4095);
            end
        end
        @(negedge clk_100);
    endtask

    task automatic reset_mid();
        check("pre_rst_locked", 64'(locked), 64'd1);
        #2 rst = 1'b1;
        #1 check("rst_async_outputs", 64'(outs), 64'd0);
        repeat (3) @(negedge clk_100);
        rst = 1'b0;
    endtask

    // Queues the report expected at this frame's starting vsync fall
    // (which describes the previous frame), then drives the frame.
    task automatic send_frame(input exp_t e, input int n_lines, input int long_idx,
                              input int rst_idx, input bit chk_ns);
        sb_q.push_back(e);
        for (int ln = 0; ln < n_lines; ln++) begin
            if (ln == rst_idx) reset_mid();
            send_line((ln < VP) ? 1'b0 : 1'b1,
                      (ln == long_idx) ? HP + 4 : HP,
                      (long_idx >= 0) && (ln == long_idx + 1),
                      chk_ns && (ln == 0));
        end
    endtask

    always @(negedge clk_100) begin
        if (frame_strobe === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL strobe_unexpected: got strobe expected none");
            end else begin
                mon_e = sb_q.pop_front();
                check("strobe_locked", 64'(locked), 64'(mon_e.lk));
                if (mon_e.chk_hp) check("strobe_h_period", 64'(h_period), 64'(mon_e.hp));
                check("strobe_h_pulse", 64'(h_pulse), 64'(mon_e.hw));
                check("strobe_v_lines", 64'(v_lines), 64'(mon_e.vl));
                check("strobe_v_pulse", 64'(v_pulse), 64'(mon_e.vp));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int waited;
        rst   = 1'b1;
        hsync = 1'b1;
        vsync = 1'b1;
        repeat (5) @(negedge clk_100);
        check("reset_outputs", 64'(outs), 64'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk_100);
        check("idle_after_release", 64'(outs), 64'd0);

        // Acquire lock from reset: SEARCH, CHECK, LOCKED
        send_frame(mk(1'b0, 1'b0, 0, 0, 0, 0), VL, -1, -1, 1'b0);
        send_frame(nom(1'b0), VL, -1, -1, 1'b0);
        send_frame(nom(1'b1), VL, -1, -1, 1'b0);

        // One long line while locked, then relock over two good frames
        send_frame(nom(1'b1), VL, 3, -1, 1'b0);
        send_frame(nom(1'b0), VL, -1, -1, 1'b0);
        send_frame(nom(1'b0), VL, -1, -1, 1'b0);
        send_frame(nom(1'b1), VL, -1, -1, 1'b0);

        // hsync stops after three lines
        send_frame(nom(1'b1), 3, -1, -1, 1'b0);
        waited = 0;
        while (no_signal !== 1'b1 && waited < 5000) begin
            @(negedge clk_100);
            waited++;
        end
        check("timeout_no_signal", 64'(no_signal), 64'd1);
        check("timeout_locked", 64'(locked), 64'd0);
        check("timeout_h_period", 64'(h_period), 64'(HP));

        send_frame(mk(1'b0, 1'b1, 4095, HW, 3, VP), VL, -1, -1, 1'b1);
        send_frame(nom(1'b0), VL, -1, -1, 1'b0);

        // Reset mid-frame while locked, then relock at third vsync fall
        send_frame(nom(1'b1), VL, -1, 5, 1'b0);
        send_frame(mk(1'b0, 1'b1, HP, HW, 5, 0), VL, -1, -1, 1'b0);
        send_frame(nom(1'b0), VL, -1, -1, 1'b0);
        send_frame(nom(1'b1), 1, -1, -1, 1'b0);

        waited = 0;
        while (sb_q.size() != 0 && waited < 200) begin
            @(negedge clk_100);
            waited++;
        end
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
